// File: rtl/tap_pkg.sv
// tap_pkg: shared types, frame constants and parity helper for the tappy link receiver
package tap_pkg;
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} tap_state_t;
  localparam int TAP_DATA_BITS = 8;
  localparam logic TAP_START = 1'b0;
  localparam logic TAP_STOP = 1'b1;
  function automatic logic tap_parity_ok(input logic [7:0] value, input logic par);
    return ^{value, par};
  endfunction
endpackage

// File: rtl/tap_sync.sv
// tap_sync: synchroniser plus run-length glitch filter for one link line
module tap_sync #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  localparam int CW = FILTER_LEN > 1 ? $clog2(FILTER_LEN) : 1;
  logic [SYNC_STAGES-1:0] sr;
  logic [CW-1:0] cnt;
  // metastability chain; resets high so an idle line never looks like an edge
  always_ff @(posedge clk or posedge reset)
    if (reset) sr <= '1;
    else sr <= {sr[SYNC_STAGES-2:0], d};
  // q follows the synchronised line only after FILTER_LEN consecutive disagreeing samples
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      q <= 1'b1;
      cnt <= '0;
    end else if (sr[SYNC_STAGES-1] == q) cnt <= '0;
    else if (cnt == CW'(FILTER_LEN - 1)) begin
      q <= sr[SYNC_STAGES-1];
      cnt <= '0;
    end else cnt <= cnt + 1'b1;
endmodule

// File: rtl/tap_rx.sv
// tap_rx: deframes start/8 data/odd parity/stop frames from the filtered link lines
module tap_rx
  import tap_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN = 4,
  parameter int TIMEOUT_CYCLES = 200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] data,
  output logic       valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic clk_f, dat_f, clk_q, fall, par;
  logic [7:0] shreg;
  logic [2:0] cnt;
  logic [TW-1:0] tcnt;
  tap_state_t state;
  tap_sync #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_clk (
    .clk(clk), .reset(reset), .d(ps2_clk), .q(clk_f)
  );
  tap_sync #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_dat (
    .clk(clk), .reset(reset), .d(ps2_dat), .q(dat_f)
  );
  assign fall = clk_q & ~clk_f;
  // previous filtered clock for falling-edge detection
  always_ff @(posedge clk or posedge reset)
    if (reset) clk_q <= 1'b1;
    else clk_q <= clk_f;
  // frame FSM with timeout abort; a link edge always takes priority over the timeout
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      shreg <= '0;
      cnt <= '0;
      par <= 1'b0;
      tcnt <= '0;
      data <= '0;
      valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err <= 1'b0;
      busy <= 1'b0;
    end else begin
      valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err <= 1'b0;
      if (fall) begin
        tcnt <= '0;
        case (state)
          IDLE: if (dat_f == TAP_START) begin
            state <= DATA;
            cnt <= '0;
            busy <= 1'b1;
          end
          DATA: begin
            shreg <= {dat_f, shreg[7:1]};
            cnt <= cnt + 1'b1;
            if (cnt == 3'(TAP_DATA_BITS - 1)) state <= PARITY;
          end
          PARITY: begin
            par <= dat_f;
            state <= STOP;
          end
          default: begin
            state <= IDLE;
            busy <= 1'b0;
            if (dat_f != TAP_STOP) frame_err <= 1'b1;
            else if (tap_parity_ok(shreg, par)) begin
              data <= shreg;
              valid <= 1'b1;
            end else parity_err <= 1'b1;
          end
        endcase
      end else if (state != IDLE) begin
        if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
          state <= IDLE;
          busy <= 1'b0;
          frame_err <= 1'b1;
          shreg <= '0;
          tcnt <= '0;
        end else tcnt <= tcnt + 1'b1;
      end
    end
endmodule

// File: doc/tap_rx.md
# tap_rx

Receiver for the tappy two-wire serial link: clock line `ps2_clk` and data line `ps2_dat`, both idle high, driven by the remote transmitter. The block synchronises and deglitches both lines into the system clock domain and deframes 11-bit frames. Each frame is a start bit (0), 8 data bits LSB-first, an odd-parity bit and a stop bit (1). It delivers each good byte with a one-cycle strobe and flags parity, framing and timeout errors. It sits between the external pins and the byte consumer.

## Interface
Parameters:
- `SYNC_STAGES`, 2: flip-flop synchroniser depth per input line, ≥2.
- `FILTER_LEN`, 4: consecutive identical synchronised samples required before a filtered line changes, ≥1.
- `TIMEOUT_CYCLES`, 200: system clocks without a filtered `ps2_clk` falling edge before an in-progress frame is aborted. This is 200 µs at the 1 MHz bench clock; the bit period is 80 µs.

Ports:
- `clk`  in  1  system clock, rising-edge.
- `reset`  in  1  asynchronous, active-high.
- `ps2_clk`  in  1  link clock, asynchronous; data is valid at its falling edge.
- `ps2_dat`  in  1  link data, asynchronous; changes while `ps2_clk` is high.
- `data`  out  8  last good byte; updated only when `valid` pulses.
- `valid`  out  1  one-cycle pulse: `data` holds a new good byte.
- `parity_err`  out  1  one-cycle pulse: parity check failed (stop bit good).
- `frame_err`  out  1  one-cycle pulse: stop bit was 0, or timeout aborted a frame.
- `busy`  out  1  high from start-bit acceptance until the frame ends.

## Operation
- Input path: each line goes through a `SYNC_STAGES` synchroniser, then the `FILTER_LEN` filter.
  - Synchroniser and filter state reset to 1, so reset cannot create a spurious edge.
  - A falling edge is filtered `ps2_clk` going 1 to 0 between consecutive cycles. The sample bit is filtered `ps2_dat` in that same cycle. Both lines share identical delay.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE, edge with bit=0: go to DATA, bit count 0, `busy`=1.
  - IDLE, edge with bit=1: ignore and stay in IDLE.
  - DATA, each edge: shift LSB-first, `shreg <= {bit, shreg[7:1]}`, and increment a 3-bit count. After the 8th bit, go to PARITY.
  - PARITY, edge: store the parity bit and go to STOP.
  - STOP, edge: evaluate the frame and return to IDLE.
    - bit=1 and `^{shreg, parity}`==1: `data<=shreg`, `valid`=1.
    - bit=1, parity bad: `parity_err`=1.
    - bit=0: `frame_err`=1 only; parity is not reported.
- Timeout counter:
  - Cleared on every edge; counts while not in IDLE.
  - Reaching `TIMEOUT_CYCLES`: pulse `frame_err`, go to IDLE, `busy`=0, and discard the partial byte.
  - If the timeout and an edge occur in the same cycle, the edge wins.
- Back-to-back frames: a start edge is accepted in the cycle after the STOP evaluation, with no idle gap required.
- `reset` mid-frame: abort immediately with no error pulse. The next start bit is received cleanly.

## Timing
- Reset values:
  - Outputs: `data`=8'h00, `valid`=0, `parity_err`=0, `frame_err`=0, `busy`=0.
  - Internal: FSM=IDLE, counters=0.
- Latency: a `ps2_clk` fall first sampled at system edge k is acted on at edge k+`SYNC_STAGES`+`FILTER_LEN`. All outputs are registered and change one cycle later.
- `valid`, `parity_err` and `frame_err` are single-cycle pulses and mutually exclusive per frame. `busy` falls in the same cycle as the end-of-frame pulse.
- Pulses narrower than `FILTER_LEN` clocks on either line are invisible.
- Data must be stable from `FILTER_LEN`+1 clocks before the filtered clock fall. The link gives 20 µs of setup.

## Structure
- Package `tap_pkg`:
  - `tap_state_t` enum (IDLE, DATA, PARITY, STOP).
  - Constants `TAP_DATA_BITS`=8, `TAP_START`=1'b0, `TAP_STOP`=1'b1.
  - Parity function `tap_parity_ok(byte, bit)`.
- Sub-module `tap_sync`: synchroniser plus filter for one line, parameterised by `SYNC_STAGES` and `FILTER_LEN`, reset value 1. It is instantiated twice.
- `tap_rx` holds edge detection, the FSM, the shift register, the timeout counter and the output registers.

## Test plan
- Frames 0xA5 (parity 1), 0x00 (parity 1), 0x01 (parity 0), 0xFF (parity 1), sent at the 80 µs bit period → four `valid` pulses; `data` = A5, 00, 01, FF in order; no error pulses.
- 0x3C sent with parity 0 → one `parity_err` pulse, no `valid`, `data` keeps its prior value; then 0x5A sent correctly → `valid`, `data`=5A.
- 0x81 sent with stop bit 0 → `frame_err` only; a following 0x42 → `valid`, `data`=42.
- Start bit plus 4 data bits, then lines held high → `frame_err` exactly `TIMEOUT_CYCLES` clocks after the last filtered edge, `busy`=0; a next frame 0x99 → `valid`, `data`=99.
- Glitch check:
  - 1-clock low pulses on `ps2_clk` while idle → no state change.
  - Same pulses between bits of 0xC3 → `data`=C3, no errors.
- `reset` asserted after the 5th data bit of 0x77, then 0x66 sent → no pulse for 0x77; `valid`, `data`=66.
- 16 random bytes back-to-back → 16 `valid` pulses matching the sent bytes.
